branch_predict_cmp: RTL and testbench
=====================================

# branch_predict_cmp

Parametrised branch comparator with an attached branch history table (BHT) of 2-bit saturating counters, for the D stage of the pipelined MIPS core.
- It resolves all six conditional branch kinds on forwarded operands.
- It supplies an F-stage taken/not-taken prediction indexed by PC and flags mispredictions for flush.
- The BHT trains on every resolved branch.
- Saturating branch and misprediction statistics counters are kept for debug.

## Interface
Parameters:
- WIDTH, 32, operand width
- IDX_BITS, 6, BHT index bits; depth = 2^IDX_BITS entries
- CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- rs  in  WIDTH  forwarded rs operand (D stage)
- rt  in  WIDTH  forwarded rt operand (D stage)
- CMPOp  in  3  branch kind: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6; 7 is treated as NONE
- lookup_pc  in  32  F-stage PC
- pred_taken  out  1  combinational prediction: BHT[lookup_pc index] bit 1
- resolve_en  in  1  D-stage branch is valid and not stalled this cycle
- resolve_pc  in  32  PC of the branch in D
- resolve_pred  in  1  prediction that accompanied this branch down the pipe
- jump  out  1  combinational branch outcome
- mispredict  out  1  combinational: resolve_en & (CMPOp≠NONE) & (jump≠resolve_pred)
- branch_cnt  out  32  resolved-branch count
- mispred_cnt  out  32  misprediction count

## Operation
- Index = pc[IDX_BITS+1:2]; word-aligned PCs, bits [1:0] ignored.
- Compare, with rs/rt taken as signed two's complement for the sign tests:
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BLEZ: rs[WIDTH-1] | (rs==0)
  - BGTZ: !rs[WIDTH-1] & (rs!=0)
  - BLTZ: rs[WIDTH-1]
  - BGEZ: !rs[WIDTH-1]
  - NONE/7: jump=0
  - rt is ignored for the zero-compare kinds.
- Training, at a rising edge with reset=1, resolve_en=1 and CMPOp valid:
  - Counter at the resolve index increments if jump=1, saturating at 3.
  - Otherwise it decrements, saturating at 0.
  - No update when resolve_en=0 or CMPOp is NONE/7.
- Statistics:
  - branch_cnt increments on every training event.
  - mispred_cnt increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
- Counter state per entry: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

## Timing
- jump, mispredict and pred_taken are zero-latency combinational.
- BHT writes and statistics updates take effect at the next rising edge.
- Same-cycle lookup and update at the same index: pred_taken returns the pre-update value. There is no write-through bypass.
- Reset (reset=0 at an edge):
  - All BHT entries become CNT_INIT.
  - branch_cnt=0 and mispred_cnt=0.
  - Any resolve in that cycle is discarded.
  - Reset asserted mid-stream simply aborts training; combinational outputs keep following their inputs.
- Outputs after reset: pred_taken=CNT_INIT[1] (0 with the default), jump and mispredict per inputs, both counters 0.
- The block has no internal stall. The pipeline must hold resolve_en low while D is stalled so that each branch trains exactly once.

## Structure
- Shared header head.v holds:
  - the CMP_NONE..CMP_BGEZ codes, extended to 3 bits; existing CMP_BEQ/CMP_BNE keep their numeric values
  - the counter encodings SNT/WNT/WT/ST
- Sub-module branch_bht: the counter array with its read port (lookup index) and update port (resolve index, taken, en), plus reset-init. The comparator, mispredict logic and statistics live in the top.

## Test plan
- Compare coverage, no resolve:
  - rs=32'hFFFF_FFFF, rt=0: BLEZ→1, BGTZ→0, BLTZ→1, BGEZ→0, BEQ→0, BNE→1.
  - rs=0: BLEZ→1, BGEZ→1, BGTZ→0.
  - CMPOp=7→jump=0.
- Saturation, resolve_pc=0x0040_0010, starting from reset:
  - Four consecutive taken BEQ (rs=rt=5) step the counter 1→2→3→3; pred_taken for the same lookup_pc=1 from the first update onward.
  - Then five not-taken steps it to 0; pred_taken=0 after the second not-taken.
- Aliasing and indexing, IDX_BITS=6:
  - Training 0x0040_0000 taken twice also flips the prediction for 0x0040_0100 (same index).
  - 0x0040_0004 is unaffected.
- Same-cycle read/write: with lookup_pc=resolve_pc, entry=1 and a taken resolve, pred_taken reads 0 in that cycle and 1 in the next.
- Mispredict and statistics:
  - 10 resolves with resolve_pred=0 and alternating outcomes: branch_cnt=10, mispred_cnt=5.
  - A cycle with resolve_en=0 changes neither count.
  - Preloading near saturation (force or long run) shows the counters hold at FFFF_FFFF.
- Reset mid-operation: reset=0 in the same cycle as a taken resolve leaves the entry at 1 and both counts at 0; normal training resumes on the first cycle after reset returns high.

Source files
------------

// File: rtl/branch_predict_cmp_pkg.sv
// Shared branch-compare codes and BHT counter encodings for the D-stage
// branch comparator and its history table.
package branch_predict_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_NONE = 3'd0,
    CMP_BEQ  = 3'd1,
    CMP_BNE  = 3'd2,
    CMP_BLEZ = 3'd3,
    CMP_BGTZ = 3'd4,
    CMP_BLTZ = 3'd5,
    CMP_BGEZ = 3'd6
  } cmp_op_e;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_e;

  // Code 7 is reserved and behaves like CMP_NONE.
  function automatic logic cmp_valid(input logic [2:0] op);
    return (op != CMP_NONE) && (op != 3'd7);
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_cmp_if.sv
// Operand, prediction and resolve signals between the pipeline and the
// branch comparator; the pipeline side is master, the comparator is slave.
interface branch_predict_cmp_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [2:0]       CMPOp;
  logic [31:0]      lookup_pc;
  logic             pred_taken;
  logic             resolve_en;
  logic [31:0]      resolve_pc;
  logic             resolve_pred;
  logic             jump;
  logic             mispredict;
  logic [31:0]      branch_cnt;
  logic [31:0]      mispred_cnt;

  modport master (
    output rs, rt, CMPOp, lookup_pc, resolve_en, resolve_pc, resolve_pred,
    input  pred_taken, jump, mispredict, branch_cnt, mispred_cnt
  );

  modport slave (
    input  rs, rt, CMPOp, lookup_pc, resolve_en, resolve_pc, resolve_pred,
    output pred_taken, jump, mispredict, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_cmp_bht.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for prediction and one clocked update port for training.
module branch_bht
  import branch_predict_cmp_pkg::*;
#(
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i,
  input  logic                wr_en_i
);
  localparam int unsigned DEPTH = 1 << IDX_BITS;

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] wr_cnt_d;

  // Reads see the stored value only; a same-cycle update is not bypassed.
  assign rd_taken_o = cnt_q[rd_idx_i][1];
  assign wr_cnt_d   = sat_step(cnt_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_cmp.sv
// D-stage branch comparator with BHT-based prediction, mispredict flagging
// and saturating debug statistics.
module branch_predict_cmp
  import branch_predict_cmp_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic                clk,
  input logic                reset,
  branch_predict_cmp_if.slave bus
);
  logic                rs_zero;
  logic                rs_neg;
  logic                rs_eq_rt;
  logic                train_en;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] resolve_idx;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  assign rs_zero  = (bus.rs == '0);
  assign rs_neg   = bus.rs[WIDTH-1];
  assign rs_eq_rt = (bus.rs == bus.rt);

  always_comb begin
    bus.jump = 1'b0;
    case (bus.CMPOp)
      CMP_BEQ:  bus.jump = rs_eq_rt;
      CMP_BNE:  bus.jump = !rs_eq_rt;
      CMP_BLEZ: bus.jump = rs_neg || rs_zero;
      CMP_BGTZ: bus.jump = !rs_neg && !rs_zero;
      CMP_BLTZ: bus.jump = rs_neg;
      CMP_BGEZ: bus.jump = !rs_neg;
      default:  bus.jump = 1'b0;
    endcase
  end

  assign train_en       = bus.resolve_en && cmp_valid(bus.CMPOp);
  assign bus.mispredict = train_en && (bus.jump != bus.resolve_pred);

  assign lookup_idx  = bus.lookup_pc[IDX_BITS+1:2];
  assign resolve_idx = bus.resolve_pc[IDX_BITS+1:2];

  branch_bht #(
    .IDX_BITS (IDX_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (lookup_idx),
    .rd_taken_o (bus.pred_taken),
    .wr_idx_i   (resolve_idx),
    .wr_taken_i (bus.jump),
    .wr_en_i    (train_en)
  );

  // Statistics stick at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (train_en && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (bus.mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_cmp.sv
// Self-checking bench for branch_predict_cmp: directed scenarios plus random
// traffic, all compared against a behavioural predictor model.
module tb_branch_predict_cmp;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int unsigned     bht_m [64];
  longint unsigned bcnt_m;
  longint unsigned mcnt_m;

  branch_predict_cmp_if #(.WIDTH(32)) bus ();

  branch_predict_cmp #(
    .WIDTH    (32),
    .IDX_BITS (6),
    .CNT_INIT (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic model_jump(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (op)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return sa <= 0;
      3'd4:    return sa > 0;
      3'd5:    return sa < 0;
      3'd6:    return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic model_train();
    return bus.resolve_en && (bus.CMPOp >= 3'd1) && (bus.CMPOp <= 3'd6);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    bcnt_m = 0;
    mcnt_m = 0;
  endtask

  // Compare all outputs against the model, then clock and advance the model.
  task automatic tick();
    logic j;
    logic mp;
    #1;
    j  = model_jump(bus.CMPOp, bus.rs, bus.rt);
    mp = model_train() && (j != bus.resolve_pred);
    chk("jump", {31'd0, bus.jump}, {31'd0, j});
    chk("mispredict", {31'd0, bus.mispredict}, {31'd0, mp});
    chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, bht_m[pc_idx(bus.lookup_pc)] >= 2});
    chk("branch_cnt", bus.branch_cnt, bcnt_m[31:0]);
    chk("mispred_cnt", bus.mispred_cnt, mcnt_m[31:0]);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (model_train()) begin
      int k;
      k = pc_idx(bus.resolve_pc);
      if (j && bht_m[k] < 3) bht_m[k]++;
      if (!j && bht_m[k] > 0) bht_m[k]--;
      if (bcnt_m < 64'hFFFF_FFFF) bcnt_m++;
      if (mp && mcnt_m < 64'hFFFF_FFFF) mcnt_m++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [31:0] rpc, input logic [31:0] lpc,
                       input logic rpred);
    bus.CMPOp        = op;
    bus.rs           = a;
    bus.rt           = b;
    bus.resolve_en   = en;
    bus.resolve_pc   = rpc;
    bus.lookup_pc    = lpc;
    bus.resolve_pred = rpred;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(3'd0, 0, 0, 1'b0, 0, 0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  logic [2:0] ops [6];
  logic [5:0] exp_a;

  initial begin
    ops = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    model_reset();
    reset = 1'b0;
    drive(3'd0, 0, 0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_branch_cnt", bus.branch_cnt, 32'd0);
    chk("rst_mispred_cnt", bus.mispred_cnt, 32'd0);
    chk("rst_pred", {31'd0, bus.pred_taken}, 32'd0);
    reset = 1'b1;

    // Compare coverage: expected BLEZ,BGTZ,BLTZ,BGEZ,BEQ,BNE = 1,0,1,0,0,1
    exp_a = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, 1'b0);
      #1 chk("cmp_neg1", {31'd0, bus.jump}, {31'd0, exp_a[5-i]});
      tick();
    end
    drive(3'd3, 0, 32'h1234, 1'b0, 0, 0, 1'b0);
    #1 chk("blez_zero", {31'd0, bus.jump}, 32'd1);
    tick();
    drive(3'd6, 0, 32'h1234, 1'b0, 0, 0, 1'b0);
    #1 chk("bgez_zero", {31'd0, bus.jump}, 32'd1);
    tick();
    drive(3'd4, 0, 32'h1234, 1'b0, 0, 0, 1'b0);
    #1 chk("bgtz_zero", {31'd0, bus.jump}, 32'd0);
    tick();
    drive(3'd7, 5, 5, 1'b1, 0, 0, 1'b1);
    #1 chk("op7_jump", {31'd0, bus.jump}, 32'd0);
    tick();

    // Saturation at one entry
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(3'd1, 5, 5, 1'b1, 32'h0040_0010, 32'h0040_0010, 1'b0);
      #1 chk("sat_up_pred", {31'd0, bus.pred_taken}, {31'd0, i != 0});
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, 5, 6, 1'b1, 32'h0040_0010, 32'h0040_0010, 1'b0);
      #1 chk("sat_dn_pred", {31'd0, bus.pred_taken}, {31'd0, i <= 1});
      tick();
    end
    drive(3'd0, 0, 0, 1'b0, 0, 32'h0040_0010, 1'b0);
    #1 chk("sat_floor_pred", {31'd0, bus.pred_taken}, 32'd0);
    tick();

    // Aliasing: 0x400000 and 0x400100 share index 0
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(3'd2, 1, 2, 1'b1, 32'h0040_0000, 0, 1'b0);
      tick();
    end
    drive(3'd0, 0, 0, 1'b0, 0, 32'h0040_0100, 1'b0);
    #1 chk("alias_pred", {31'd0, bus.pred_taken}, 32'd1);
    tick();
    drive(3'd0, 0, 0, 1'b0, 0, 32'h0040_0004, 1'b0);
    #1 chk("neighbour_pred", {31'd0, bus.pred_taken}, 32'd0);
    tick();

    // Same-cycle lookup and update: no bypass
    drive(3'd5, 32'h8000_0000, 0, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b1);
    #1 chk("rw_same_cycle", {31'd0, bus.pred_taken}, 32'd0);
    tick();
    drive(3'd0, 0, 0, 1'b0, 0, 32'h0040_0020, 1'b0);
    #1 chk("rw_next_cycle", {31'd0, bus.pred_taken}, 32'd1);
    tick();

    // Statistics: 10 resolves, every other one taken, all predicted not-taken
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(3'd1, 7, (i % 2 == 0) ? 32'd7 : 32'd8, 1'b1, 32'h0040_0040 + 32'(i * 4),
            0, 1'b0);
      #1 chk("stat_mispredict", {31'd0, bus.mispredict}, {31'd0, i % 2 == 0});
      tick();
    end
    drive(3'd1, 7, 7, 1'b0, 32'h0040_0040, 0, 1'b0);
    #1 chk("stat_branch_cnt", bus.branch_cnt, 32'd10);
    chk("stat_mispred_cnt", bus.mispred_cnt, 32'd5);
    tick();
    #1 chk("idle_branch_cnt", bus.branch_cnt, 32'd10);
    chk("idle_mispred_cnt", bus.mispred_cnt, 32'd5);

    // Reset coinciding with a taken resolve
    reset = 1'b0;
    drive(3'd1, 3, 3, 1'b1, 32'h0040_0030, 32'h0040_0030, 1'b0);
    tick();
    reset = 1'b1;
    drive(3'd1, 3, 3, 1'b1, 32'h0040_0030, 32'h0040_0030, 1'b0);
    #1 chk("midrst_pred", {31'd0, bus.pred_taken}, 32'd0);
    chk("midrst_branch_cnt", bus.branch_cnt, 32'd0);
    chk("midrst_mispred_cnt", bus.mispred_cnt, 32'd0);
    tick();
    drive(3'd0, 0, 0, 1'b0, 0, 32'h0040_0030, 1'b0);
    #1 chk("resume_pred", {31'd0, bus.pred_taken}, 32'd1);
    chk("resume_branch_cnt", bus.branch_cnt, 32'd1);
    chk("resume_mispred_cnt", bus.mispred_cnt, 32'd1);
    tick();

    // Random traffic, with occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rpc;
      b   = $urandom;
      case ($urandom % 4)
        0:       a = 32'd0;
        1:       a = b;
        default: a = $urandom;
      endcase
      rpc = 32'h0040_0000 + 32'(($urandom % 128) * 4);
      reset = ($urandom % 50) != 0;
      drive(3'($urandom % 8), a, b, 1'($urandom % 4 != 0), rpc,
            ($urandom % 3 == 0) ? rpc : 32'h0040_0000 + 32'(($urandom % 128) * 4),
            1'($urandom));
      tick();
    end
    reset = 1'b1;

    // Statistics saturation from a preloaded near-full value
    force dut.branch_cnt_q  = 32'hFFFF_FFFE;
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    bcnt_m = 64'hFFFF_FFFE;
    mcnt_m = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(3'd2, 1, 1, 1'b1, 32'h0040_0008, 0, 1'b1);
      tick();
    end
    #1 chk("sat_branch_cnt", bus.branch_cnt, 32'hFFFF_FFFF);
    chk("sat_mispred_cnt", bus.mispred_cnt, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
